// File: rtl/arb_pkg.sv
// Shared types and sizing helpers for the weighted round-robin burst arbiter.
package arb_pkg;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Index width never drops to zero so a single-channel build still has a port.
  function automatic int idx_width(input int w);
    return (w > 1) ? clog2(w) : 1;
  endfunction

  function automatic int cnt_width(input int bm);
    return clog2(bm + 1);
  endfunction

  localparam int BURST_MAX_DEF = 16;
  localparam int CNT_W_DEF     = cnt_width(BURST_MAX_DEF);

endpackage

// File: rtl/rr_pick.sv
// Rotating priority encoder: first set mask bit after pointer, wrapping.
module rr_pick import arb_pkg::*; #(
  parameter int WIDTH = 6,
  parameter int IW    = 3
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [IW-1:0]    pointer,
  output logic [WIDTH-1:0] grant,
  output logic [IW-1:0]    index,
  output logic             any
);

  int j;

  always_comb begin
    grant = '0;
    index = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = 1; k <= WIDTH; k++) begin
      j = int'(pointer) + k;
      if (j >= WIDTH) j = j - WIDTH;
      if (!any && mask[j]) begin
        any      = 1'b1;
        grant[j] = 1'b1;
        index    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wrr_burst_arbiter.sv
// Merges per-source FWFT FIFOs into one registered valid/ready stream with
// runtime enables, a per-grant burst limit and hold-to-keep-ownership.
module wrr_burst_arbiter import arb_pkg::*; #(
  parameter int WIDTH     = 6,
  parameter int DSIZE     = 32,
  parameter int BURST_MAX = 16
) (
  input  logic                        CLK,
  input  logic                        RST_B,
  input  logic [WIDTH-1:0]            CHANNEL_EN,
  input  logic [WIDTH-1:0]            WRITE_REQ,
  input  logic [WIDTH-1:0]            HOLD_REQ,
  input  logic [WIDTH*DSIZE-1:0]      DATA_IN,
  output logic [WIDTH-1:0]            READ_GRANT,
  input  logic                        READY_IN,
  output logic                        WRITE_OUT,
  output logic [DSIZE-1:0]            DATA_OUT,
  output logic [idx_width(WIDTH)-1:0] ACTIVE_CH,
  output logic                        BUSY
);

  localparam int IW = idx_width(WIDTH);
  localparam int CW = cnt_width(BURST_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST_MAX);

  state_t           state;
  logic [IW-1:0]    owner, ptr;
  logic [WIDTH-1:0] own_oh;
  logic [CW-1:0]    cnt, cnt_nxt;

  logic [WIDTH-1:0] elig, pick_grant;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;
  logic             own_en, own_req, own_hold, pop, rel;

  assign elig = WRITE_REQ & CHANNEL_EN;

  rr_pick #(.WIDTH(WIDTH), .IW(IW)) u_pick (
    .mask    (elig),
    .pointer (ptr),
    .grant   (pick_grant),
    .index   (pick_idx),
    .any     (pick_any)
  );

  assign own_en   = CHANNEL_EN[owner];
  assign own_req  = WRITE_REQ[owner];
  assign own_hold = HOLD_REQ[owner];

  // A full output register that is not draining blocks the pop.
  assign pop = (state == GRANT) & own_req & own_en & (~WRITE_OUT | READY_IN)
             & ((cnt < CNT_MAX) | own_hold);

  assign cnt_nxt = (pop && (cnt != CNT_MAX)) ? cnt + CW'(1) : cnt;

  // Disable wins over hold; otherwise hold suppresses empty and burst-limit release.
  assign rel = ~own_en | (~own_hold & (~own_req | (cnt_nxt == CNT_MAX)));

  assign READ_GRANT = own_oh & {WIDTH{pop}};

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      state     <= IDLE;
      owner     <= '0;
      own_oh    <= '0;
      ptr       <= IW'(WIDTH - 1);
      cnt       <= '0;
      WRITE_OUT <= 1'b0;
      DATA_OUT  <= '0;
      ACTIVE_CH <= '0;
      BUSY      <= 1'b0;
    end else begin
      if (pop) begin
        DATA_OUT  <= DATA_IN[owner*DSIZE +: DSIZE];
        WRITE_OUT <= 1'b1;
      end else if (WRITE_OUT && READY_IN) begin
        WRITE_OUT <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_any) begin
            owner     <= pick_idx;
            own_oh    <= pick_grant;
            ACTIVE_CH <= pick_idx;
            cnt       <= '0;
            BUSY      <= 1'b1;
            state     <= GRANT;
          end
        end
        GRANT: begin
          cnt <= cnt_nxt;
          if (rel) begin
            ptr   <= owner;
            BUSY  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
